// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave sequencing a single-port SRAM, with one wait state on write-then-read conflicts.
module ahb_sram_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [31:0]       MEM_D,
  output logic              MEM_CEN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BWEN,
  input  logic [31:0]       MEM_Q
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2, RWAIT = 3'd3, ERR1 = 3'd4, ERR2 = 3'd5;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        bwen_q, bwen_d;
  logic              accept, illegal, rd_now, wr_cyc, rw_cyc;
  logic [3:0]        lanes;
  logic              unused;
  assign unused  = ^{HADDR[31:ADDR_W+2], HTRANS[0]};
  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = (HSIZE > 3'd2) | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & HADDR[1:0] != 2'b00);
  assign lanes   = HSIZE == 3'd0 ? ~(4'b0001 << HADDR[1:0]) :
                   HSIZE == 3'd1 ? (HADDR[1] ? 4'b0011 : 4'b1100) : 4'b0000;
  assign wr_cyc  = state_q == WRITE;
  assign rw_cyc  = state_q == RWAIT;
  // The SRAM port is busy with the previous write in WRITE, so a read accepted then is deferred to RWAIT.
  assign rd_now  = accept & ~illegal & ~HWRITE & ~wr_cyc & ~RST;
  always_comb begin
    state_d = IDLE;
    addr_d  = addr_q;
    bwen_d  = bwen_q;
    if (rw_cyc) state_d = READ;
    else if (state_q == ERR1) state_d = ERR2;
    else if (accept) begin
      if (illegal) state_d = ERR1;
      else if (HWRITE) begin
        state_d = WRITE;
        addr_d  = HADDR[ADDR_W+1:2];
        bwen_d  = lanes;
      end else if (wr_cyc) begin
        state_d = RWAIT;
        addr_d  = HADDR[ADDR_W+1:2];
      end else state_d = READ;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bwen_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bwen_q  <= bwen_d;
    end
  end
  assign MEM_CEN   = RST | ~(rd_now | wr_cyc | rw_cyc);
  assign MEM_WEN   = ~wr_cyc;
  assign MEM_A     = (wr_cyc | rw_cyc) ? addr_q : HADDR[ADDR_W+1:2];
  assign MEM_D     = HWDATA;
  assign MEM_BWEN  = wr_cyc ? bwen_q : (rd_now | rw_cyc) ? 4'b0000 : 4'hF;
  assign HREADYOUT = ~(rw_cyc | state_q == ERR1);
  assign HRESP     = state_q == ERR1 | state_q == ERR2;
  assign HRDATA    = state_q == READ ? MEM_Q : '0;
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed AHB transfers against a behavioural SRAM, scoreboarded bus responses and SRAM cycles.
module tb_ahb_sram_ctrl;
  logic        CLK, RST, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, MEM_CEN, MEM_WEN;
  logic [31:0] HADDR, HWDATA, HRDATA, MEM_D, MEM_Q;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [15:0] MEM_A;
  logic [3:0]  MEM_BWEN;
  logic [31:0] prev_wd;
  logic [31:0] mem [0:1023];
  int nvec = 0, nfail = 0;
  typedef struct packed { logic [31:0] d; logic resp; logic [31:0] waits; } rsp_t;
  typedef struct packed { logic [15:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  rsp_t        rsp_q[$];
  wr_t         wq[$];
  logic [15:0] rq[$];
  assign HREADY = HREADYOUT;
  ahb_sram_ctrl #(.ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_CEN(MEM_CEN), .MEM_WEN(MEM_WEN),
    .MEM_BWEN(MEM_BWEN), .MEM_Q(MEM_Q)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  // Behavioural 1-cycle-latency SRAM with active-low byte enables.
  initial begin
    MEM_Q = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    forever begin
      @(posedge CLK);
      if (!MEM_CEN) begin
        if (!MEM_WEN) begin
          for (int b = 0; b < 4; b++) if (!MEM_BWEN[b]) mem[MEM_A[9:0]][8*b+:8] = MEM_D[8*b+:8];
        end else MEM_Q <= mem[MEM_A[9:0]];
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Monitor: pops expected SRAM cycles and data-phase responses as the DUT presents them.
  initial begin
    logic pending;
    int   waits;
    rsp_t r;
    wr_t  w;
    pending = 0;
    waits   = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("rst_cen", MEM_CEN, 1);
        chk("rst_hready", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        pending = 0;
        waits   = 0;
      end else begin
        if (!MEM_CEN) begin
          if (!MEM_WEN) begin
            if (wq.size() == 0) chk("unexpected_sram_write", 1, 0);
            else begin
              w = wq.pop_front();
              chk("mem_a_wr", {16'h0, MEM_A}, {16'h0, w.a});
              chk("mem_d", MEM_D, w.d);
              chk("mem_bwen_wr", {28'h0, MEM_BWEN}, {28'h0, w.be});
            end
          end else begin
            if (rq.size() == 0) chk("unexpected_sram_read", 1, 0);
            else begin
              chk("mem_a_rd", {16'h0, MEM_A}, {16'h0, rq.pop_front()});
              chk("mem_bwen_rd", {28'h0, MEM_BWEN}, 0);
            end
          end
        end
        if (pending && !HREADYOUT) waits++;
        else begin
          if (pending) begin
            if (rsp_q.size() == 0) chk("unexpected_response", 1, 0);
            else begin
              r = rsp_q.pop_front();
              chk("hresp", HRESP, r.resp);
              chk("hrdata", HRDATA, r.d);
              chk("wait_states", waits, r.waits);
            end
          end else begin
            chk("idle_hready", HREADYOUT, 1);
            chk("idle_hresp", HRESP, 0);
          end
          pending = HSEL & HREADY & HTRANS[1];
          waits   = 0;
        end
      end
    end
  end
  task automatic step();
    int n = 0;
    forever begin
      @(negedge CLK);
      if (HREADYOUT) break;
      if (++n > 20) begin
        $display("FAIL hready_timeout: got 0 expected 1");
        $fatal(1, "bus stalled");
      end
    end
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    HTRANS = 2'b10;
    HWRITE = w;
    HADDR  = a;
    HSIZE  = sz;
    HWDATA = prev_wd;
    step();
    prev_wd = wd;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      HTRANS = 2'b00;
      HWDATA = prev_wd;
      step();
    end
  endtask
  task automatic exp_rsp(input logic [31:0] d, input logic resp, input int waits);
    rsp_q.push_back('{d: d, resp: resp, waits: waits});
  endtask
  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    wq.push_back('{a: a, d: d, be: be});
  endtask
  initial begin
    RST = 1; HSEL = 1; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 0; HWDATA = 0; prev_wd = 0;
    #22 RST = 0;
    idle(3);
    // Write then read with no gap: one wait state, deferred read from 0x20.
    exp_wr(16'h4, 32'h1234_5678, 4'b0000); exp_rsp(0, 0, 0);
    issue(1, 32'h10, 3'd2, 32'h1234_5678);
    rq.push_back(16'h8); exp_rsp(0, 0, 1);
    issue(0, 32'h20, 3'd2, 0);
    exp_wr(16'h40, 32'hAABB_CCDD, 4'b0000); exp_rsp(0, 0, 0);
    issue(1, 32'h100, 3'd2, 32'hAABB_CCDD);
    rq.push_back(16'h40); exp_rsp(32'hAABB_CCDD, 0, 1);
    issue(0, 32'h100, 3'd2, 0);
    // Sub-word lanes.
    exp_wr(16'h40, 32'hEE00_0000, 4'b0111); exp_rsp(0, 0, 0);
    issue(1, 32'h103, 3'd0, 32'hEE00_0000);
    exp_wr(16'h40, 32'h5566_0000, 4'b0011); exp_rsp(0, 0, 0);
    issue(1, 32'h102, 3'd1, 32'h5566_0000);
    rq.push_back(16'h40); exp_rsp(32'h5566_CCDD, 0, 1);
    issue(0, 32'h100, 3'd2, 0);
    // Illegal transfers, back-to-back through ERR2, then a normal read from ERR2.
    exp_rsp(0, 1, 1);
    issue(1, 32'h2, 3'd2, 32'hDEAD_BEEF);
    exp_rsp(0, 1, 1);
    issue(0, 32'h0, 3'd3, 0);
    exp_rsp(0, 1, 1);
    issue(0, 32'h101, 3'd1, 0);
    rq.push_back(16'h40); exp_rsp(32'h5566_CCDD, 0, 0);
    issue(0, 32'h100, 3'd2, 0);
    idle(2);
    // Reset during a write data phase drops the write.
    exp_wr(16'h80, 32'h1111_2222, 4'b0000); exp_rsp(0, 0, 0);
    issue(1, 32'h200, 3'd2, 32'h1111_2222);
    idle(1);
    issue(1, 32'h200, 3'd2, 32'h9999_9999);
    HTRANS = 2'b00;
    HWDATA = prev_wd;
    #2 RST = 1;
    @(posedge CLK);
    #3 RST = 0;
    idle(1);
    rq.push_back(16'h80); exp_rsp(32'h1111_2222, 0, 0);
    issue(0, 32'h200, 3'd2, 0);
    idle(1);
    // Four back-to-back writes, zero wait.
    for (int i = 0; i < 4; i++) begin
      exp_wr(16'hC0 + 16'(i), 32'hC0DE_0000 + 32'(i), 4'b0000); exp_rsp(0, 0, 0);
      issue(1, 32'h300 + 32'(4 * i), 3'd2, 32'hC0DE_0000 + 32'(i));
    end
    idle(3);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("wr_q_drained", wq.size(), 0);
    chk("rd_q_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave front-end that sequences the 64Kx32 single-port SRAM wrapper (256 KB, word-addressed, 1-cycle read latency, active-low CEN/WEN/BWEN).
- Converts AHB address/data-phase transfers into SRAM cycles and resolves the single-port write-then-read conflict with one wait state.
- Generates byte lanes from HSIZE/HADDR and returns ERROR for illegal transfers.
- Sits between the AHB interconnect and the memory wrapper inside ahb_sram.

Parameters:
- ADDR_W, 16, SRAM word-address width; the SRAM address is HADDR[ADDR_W+1:2], upper HADDR bits are ignored.

Ports:
- CLK in 1: system clock, all logic rising-edge.
- RST in 1: asynchronous reset, active-high.
- HSEL in 1: slave select.
- HADDR in 32: AHB address.
- HTRANS in 2: AHB transfer type.
- HWRITE in 1: 1 = write.
- HSIZE in 3: transfer size.
- HWDATA in 32: write data, valid in data phase.
- HREADY in 1: bus ready.
- HREADYOUT out 1: slave ready.
- HRESP out 1: 0 = OKAY, 1 = ERROR.
- HRDATA out 32: read data.
- MEM_A out ADDR_W: SRAM word address.
- MEM_D out 32: SRAM write data.
- MEM_CEN out 1: SRAM chip enable, active-low.
- MEM_WEN out 1: SRAM write enable, active-low.
- MEM_BWEN out 4: byte write enables, active-low, bit n = byte n.
- MEM_Q in 32: SRAM read data, valid the cycle after a read CEN.

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS[1]. IDLE/BUSY transfers get OKAY with zero wait states.
- Illegal transfers: HSIZE > 2, or HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]!=0.
- Lane map (active-low BWEN):
  - byte: bit HADDR[1:0] low.
  - half: HADDR[1]=0 -> 4'b1100, HADDR[1]=1 -> 4'b0011.
  - word: 4'b0000.
  - reads drive 4'b0000.
- FSM states: IDLE, WRITE, READ, RWAIT, ERR1, ERR2.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, MEM_CEN=1, MEM_WEN=1, MEM_BWEN=4'hF, address/lane registers=0. While RST is high, MEM_CEN is forced to 1 combinationally.
- Read accept, when not in WRITE: same cycle, MEM_CEN=0, MEM_WEN=1, MEM_A from HADDR (combinational). Next state READ.
- READ: HRDATA=MEM_Q, HREADYOUT=1, HRESP=0. Zero-wait read. Outside READ, HRDATA=0.
- Write accept: register word address and BWEN. Next state WRITE.
- WRITE: MEM_CEN=0, MEM_WEN=0, MEM_A=registered address, MEM_D=HWDATA (combinational), MEM_BWEN=registered lanes, HREADYOUT=1.
- Write followed by write: back-to-back, zero wait. The new address is registered while the previous write fires.
- Read accepted while in WRITE (port conflict):
  - Register the read address; no SRAM read that cycle. Next state RWAIT.
  - RWAIT: issue the read from the registered address, HREADYOUT=0. Next state READ.
  - Net effect: exactly one wait state; read data reflects the just-completed write (no stale data).
- Illegal accept: no SRAM access. Next state ERR1.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - A transfer accepted during ERR2 is handled normally.
- No accept in READ/WRITE/ERR2 -> IDLE. In IDLE: HREADYOUT=1, HRESP=0, MEM_CEN=1.
- Asynchronous reset mid-transfer: any pending write in WRITE is dropped, and an RWAIT read is dropped. Outputs return to reset values immediately.

Test Plan:
- Reset release, idle bus -> HREADYOUT=1, HRESP=0, MEM_CEN=1 every cycle; IDLE transfers complete OKAY with zero wait.
- Word write 0x1234_5678 to HADDR 0x0000_0010, then word read from 0x0000_0020 with no idle cycle between them:
  - write data phase: MEM_A=4, MEM_WEN=0, MEM_BWEN=0000.
  - read: one cycle with HREADYOUT=0 (RWAIT), then MEM_A=8 read.
- Write 0xAABBCCDD to 0x0000_0100, then back-to-back read of 0x0000_0100 -> one wait state, HRDATA=0xAABBCCDD.
- Byte write 0xEE at 0x0000_0103, then halfword write 0x5566 at 0x0000_0102:
  - lanes 0111, then 0011.
  - read of 0x100 returns 0x5566CCDD.
- Word access at 0x0000_0002 (misaligned) -> no MEM_CEN low; ERR1 cycle (HREADYOUT=0, HRESP=1), then ERR2 cycle (HREADYOUT=1, HRESP=1). HSIZE=3 gives the same response.
- RST asserted during the WRITE data phase of a write to 0x0000_0200 -> MEM_CEN=1 immediately. After release, reading 0x200 returns the prior contents.
- Four back-to-back writes to 0x300..0x30C -> zero wait states; MEM_A=0xC0,0xC1,0xC2,0xC3 on consecutive cycles.
